key_expansion: RTL and testbench



---
 rtl/key_expansion.sv | 177 +++++++++++++++++
 tb/tb_key_expansion.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion.sv
// AES-128 key schedule: streams round keys 0..10 one per clock after a start pulse.
// Optional feature: define KEY_STORE_EN to keep all 11 round keys in a register
// array that can be read back through rd_addr/rd_data (1-cycle read latency).
module key_expansion (
  input  logic         CLK,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic [127:0] round_key,
  output logic         done,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_data
);

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBox = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [3:0] LastIdx = 4'd10;

  typedef enum logic [0:0] {StIdle, StExpand} state_e;

  // Combinational byte substitution; one call per byte of the rotated word.
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBox[8 * (255 - int'(b)) +: 8];
  endfunction

  // 8-bit doubling in GF(2^8) for the round constant.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_e         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [3:0]     idx_q, idx_d;
  logic [7:0]     rcon_q, rcon_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;

  logic [31:0]    w0, w1, w2, w3, rot, sub, t;
  logic [31:0]    n0, n1, n2, n3;
  logic [127:0]   next_key;

  // One full round of the schedule from the current round key.
  always_comb begin
    w0  = key_q[127:96];
    w1  = key_q[95:64];
    w2  = key_q[63:32];
    w3  = key_q[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sub_byte(rot[31:24]), sub_byte(rot[23:16]),
           sub_byte(rot[15:8]),  sub_byte(rot[7:0])};
    t   = sub ^ {rcon_q, 24'h0};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // Next-state logic for the IDLE/EXPAND controller and output registers.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          key_d   = key_in;
          idx_d   = 4'd0;
          valid_d = 1'b1;
          rcon_d  = 8'h01;
          busy_d  = 1'b1;
          state_d = StExpand;
        end
      end
      StExpand: begin
        if (idx_q == LastIdx) begin
          // Round key and index hold their final values.
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          key_d  = next_key;
          idx_d  = idx_q + 4'd1;
          rcon_d = xtime(rcon_q);
          done_d = (idx_q == LastIdx - 4'd1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      idx_q   <= '0;
      rcon_q  <= 8'h01;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign rk_valid  = valid_q;
  assign rk_idx    = idx_q;
  assign round_key = key_q;
  assign done      = done_q;

`ifdef KEY_STORE_EN
  logic [127:0] store_q [11];
  logic [127:0] rd_data_q;

  // Capture each presented round key; registered read port sees pre-write data.
  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) begin
        store_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (valid_q) begin
        store_q[idx_q] <= key_q;
      end
      if (rd_addr <= LastIdx) begin
        rd_data_q <= store_q[rd_addr];
      end else begin
        rd_data_q <= '0;
      end
    end
  end

  assign rd_data = rd_data_q;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data = '0;
`endif

endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion; honours KEY_STORE_EN like the design.
module tb_key_expansion;

  logic         CLK;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] round_key;
  logic         done;
  logic [3:0]   rd_addr;
  logic [127:0] rd_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    logic         care;
    logic         done;
  } exp_t;

  exp_t exp_q[$];

  logic [127:0] fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] fips_rk [11];
  logic [127:0] zero_rk1  = 128'h62636363626363636263636362636363;
  logic [127:0] zero_rk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  key_expansion dut (
    .CLK       (CLK),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk_idx    (rk_idx),
    .round_key (round_key),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic push_fips();
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      e.idx  = 4'(i);
      e.key  = fips_rk[i];
      e.care = 1'b1;
      e.done = (i == 10);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_zero();
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      e.idx  = 4'(i);
      e.key  = (i == 1) ? zero_rk1 : (i == 10) ? zero_rk10 : '0;
      e.care = (i == 0) || (i == 1) || (i == 10);
      e.done = (i == 10);
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; key_in = '0; rd_addr = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rk_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (rk_idx !== 4'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", rk_idx); end
    checks++; if (round_key !== '0) begin errors++; $display("FAIL reset_key got %h want 0", round_key); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    @(negedge CLK);
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", rk_valid); end
  endtask

  task automatic test_fips();
    exp_t e;
    @(negedge CLK);
    key_in = fips_key; start = 1'b1;
    push_fips();
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      e = exp_q.pop_front();
      checks++; if (rk_valid !== 1'b1) begin errors++; $display("FAIL fips_valid i=%0d got %b want 1", i, rk_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fips_busy i=%0d got %b want 1", i, busy); end
      checks++; if (rk_idx !== e.idx) begin errors++; $display("FAIL fips_idx got %0d want %0d", rk_idx, e.idx); end
      checks++; if (round_key !== e.key) begin errors++; $display("FAIL fips_key idx=%0d got %h want %h", e.idx, round_key, e.key); end
      checks++; if (done !== e.done) begin errors++; $display("FAIL fips_done idx=%0d got %b want %b", e.idx, done, e.done); end
      key_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge CLK);
    end
    checks++; if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL fips_end busy/valid/done got %b%b%b want 000", busy, rk_valid, done);
    end
    checks++; if (round_key !== fips_rk[10] || rk_idx !== 4'd10) begin
      errors++; $display("FAIL fips_hold got %0d %h want 10 %h", rk_idx, round_key, fips_rk[10]);
    end
  endtask

  task automatic test_zero_key();
    exp_t e;
    @(negedge CLK);
    key_in = '0; start = 1'b1;
    push_zero();
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      e = exp_q.pop_front();
      checks++; if (rk_valid !== 1'b1) begin errors++; $display("FAIL zero_valid i=%0d got %b want 1", i, rk_valid); end
      checks++; if (rk_idx !== e.idx) begin errors++; $display("FAIL zero_idx got %0d want %0d", rk_idx, e.idx); end
      if (e.care) begin
        checks++; if (round_key !== e.key) begin errors++; $display("FAIL zero_key idx=%0d got %h want %h", e.idx, round_key, e.key); end
      end
      checks++; if (done !== e.done) begin errors++; $display("FAIL zero_done idx=%0d got %b want %b", e.idx, done, e.done); end
      @(negedge CLK);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_fall got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(negedge CLK);
    key_in = fips_key; start = 1'b1;
    push_fips();
    @(negedge CLK);
    // start stays high throughout; key_in churns every cycle
    for (int i = 0; i < 11; i++) begin
      e = exp_q.pop_front();
      checks++; if (rk_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid i=%0d got %b want 1", i, rk_valid); end
      checks++; if (rk_idx !== e.idx) begin errors++; $display("FAIL b2b_idx got %0d want %0d", rk_idx, e.idx); end
      checks++; if (round_key !== e.key) begin errors++; $display("FAIL b2b_key idx=%0d got %h want %h", e.idx, round_key, e.key); end
      checks++; if (done !== e.done) begin errors++; $display("FAIL b2b_done idx=%0d got %b want %b", e.idx, done, e.done); end
      key_in = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
      @(negedge CLK);
    end
    checks++; if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_gap busy/valid got %b%b want 00", busy, rk_valid);
    end
    key_in = '0;
    push_zero();
    @(negedge CLK);
    for (int i = 0; i < 11; i++) begin
      e = exp_q.pop_front();
      checks++; if (rk_valid !== 1'b1) begin errors++; $display("FAIL b2b2_valid i=%0d got %b want 1", i, rk_valid); end
      checks++; if (rk_idx !== e.idx) begin errors++; $display("FAIL b2b2_idx got %0d want %0d", rk_idx, e.idx); end
      if (e.care) begin
        checks++; if (round_key !== e.key) begin errors++; $display("FAIL b2b2_key idx=%0d got %h want %h", e.idx, round_key, e.key); end
      end
      start = 1'b0;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge CLK);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b2_end busy got %b want 0", busy); end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    @(negedge CLK);
    key_in = fips_key; start = 1'b1;
    push_fips();
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      checks++; if (rk_idx !== e.idx || round_key !== e.key) begin
        errors++; $display("FAIL abort_pre idx got %0d %h want %0d %h", rk_idx, round_key, e.idx, e.key);
      end
      if (i < 5) @(negedge CLK);
    end
    exp_q.delete();
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    checks++; if ({busy, rk_valid, done} !== 3'b000) begin
      errors++; $display("FAIL abort_ctl busy/valid/done got %b%b%b want 000", busy, rk_valid, done);
    end
    checks++; if (rk_idx !== 4'd0 || round_key !== '0 || rd_data !== '0) begin
      errors++; $display("FAIL abort_data got %0d %h %h want 0 0 0", rk_idx, round_key, rd_data);
    end
    repeat (3) begin
      @(negedge CLK);
      checks++; if (done !== 1'b0 || rk_valid !== 1'b0) begin
        errors++; $display("FAIL abort_quiet done/valid got %b%b want 00", done, rk_valid);
      end
    end
  endtask

  task automatic test_key_store();
    logic [3:0]   addrs [4];
    logic [127:0] want;
    addrs[0] = 4'd1; addrs[1] = 4'd10; addrs[2] = 4'd15; addrs[3] = 4'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      rd_addr = addrs[i];
`ifdef KEY_STORE_EN
      want = (addrs[i] <= 4'd10) ? fips_rk[addrs[i]] : '0;
`else
      want = '0;
`endif
      @(negedge CLK);
      checks++; if (rd_data !== want) begin
        errors++; $display("FAIL store_read addr=%0d got %h want %h", addrs[i], rd_data, want);
      end
    end
  endtask

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    test_reset();
    test_fips();
    test_zero_key();
    test_back_to_back();
    test_reset_abort();
    test_fips();
    test_key_store();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
